// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the icache frame, address-view and FSM types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking fill FSM.
// Optional hit/miss statistics ports are added when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    logic [SETS-1:0] valid_r;
    logic [TAGW-1:0] tag_r [SETS];
    word_t           data_r [SETS];

    icache_state_t   state_r;
    icache_state_t   nextState_s;
    logic [29:0]     latchAddr_r;

    logic [IDX-1:0]  reqIdx_s;
    logic [TAGW-1:0] reqTag_s;
    logic [IDX-1:0]  fillIdx_s;
    logic [TAGW-1:0] fillTag_s;
    logic            lookupHit_s;
    logic            startFill_s;
    logic            fillDone_s;
    logic            unusedBits_s;

    assign reqIdx_s     = imemaddr[IDX+1:2];
    assign reqTag_s     = imemaddr[31:IDX+2];
    assign fillIdx_s    = latchAddr_r[IDX-1:0];
    assign fillTag_s    = latchAddr_r[29:IDX];
    assign lookupHit_s  = imemREN & valid_r[reqIdx_s] & (tag_r[reqIdx_s] == reqTag_s);
    assign unusedBits_s = ^imemaddr[1:0];

    // Next-state and output decode; a fill always runs to completion once started.
    always_comb begin
        nextState_s = state_r;
        ihit        = 1'b0;
        imemload    = 32'h0000_0000;
        iREN        = 1'b0;
        iaddr       = 32'h0000_0000;
        startFill_s = 1'b0;
        fillDone_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (lookupHit_s) begin
                    ihit     = 1'b1;
                    imemload = data_r[reqIdx_s];
                end else if (imemREN) begin
                    startFill_s = 1'b1;
                    nextState_s = FILL;
                end else begin
                    nextState_s = IDLE;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {latchAddr_r, 2'b00};
                if (!iwait) begin
                    fillDone_s  = 1'b1;
                    nextState_s = IDLE;
                end else begin
                    nextState_s = FILL;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // FSM state, latched miss address and valid bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            latchAddr_r <= 30'h0;
            valid_r     <= '0;
        end else begin
            state_r <= nextState_s;
            if (startFill_s) begin
                latchAddr_r <= imemaddr[31:2];
            end else begin
                latchAddr_r <= latchAddr_r;
            end
            if (fillDone_s) begin
                valid_r[fillIdx_s] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge CLK) begin
        if (fillDone_s) begin
            tag_r[fillIdx_s]  <= fillTag_s;
            data_r[fillIdx_s] <= iload;
        end else begin
            tag_r[fillIdx_s]  <= tag_r[fillIdx_s];
            data_r[fillIdx_s] <= data_r[fillIdx_s];
        end
    end

`ifdef ICACHE_STATS_EN
    // Statistics: hits per cycle, misses per fill start; both wrap naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0000_0000;
            miss_count <= 32'h0000_0000;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                hit_count <= hit_count;
            end
            if (startFill_s) begin
                miss_count <= miss_count + 32'd1;
            end else begin
                miss_count <= miss_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (SETS=16); stats checks under ICACHE_STATS_EN.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
`ifdef ICACHE_STATS_EN
    word_t hit_count;
    word_t miss_count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-low-phase, then let combinational outputs settle.
    task automatic cyc(input logic ren, input word_t addr, input logic wt, input word_t ld);
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    task automatic expOut(input string tag, input logic eHit, input word_t eLoad,
                          input logic eRen, input word_t eAddr);
        chk({tag, ".ihit"},     {31'h0, ihit},  {31'h0, eHit});
        chk({tag, ".imemload"}, imemload,       eLoad);
        chk({tag, ".iREN"},     {31'h0, iREN},  {31'h0, eRen});
        chk({tag, ".iaddr"},    iaddr,          eAddr);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        #12;
        expOut("reset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("reset.hit_count", hit_count, 32'h0);
        chk("reset.miss_count", miss_count, 32'h0);
`endif
        @(negedge CLK); nRST = 1'b1;

        // Cold miss on 0x40, three wait cycles then data.
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
        expOut("miss40", 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
            expOut("fill40.wait", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        end
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'h8C22_0004);
        expOut("fill40.done", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        expOut("hit40", 1'b1, 32'h8C22_0004, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0043, 1'b1, 32'h0);
        expOut("hit40.again", 1'b1, 32'h8C22_0004, 1'b0, 32'h0);
        cyc(1'b0, 32'h0000_0040, 1'b1, 32'h0);
        expOut("noreq", 1'b0, 32'h0, 1'b0, 32'h0);

        // Conflict on index 0: 0x440 evicts 0x40.
        cyc(1'b1, 32'h0000_0440, 1'b1, 32'h0);
        expOut("miss440", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0440, 1'b0, 32'h1111_1111);
        expOut("fill440", 1'b0, 32'h0, 1'b1, 32'h0000_0440);
        cyc(1'b1, 32'h0000_0440, 1'b1, 32'h0);
        expOut("hit440", 1'b1, 32'h1111_1111, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        expOut("remiss40", 1'b0, 32'h0, 1'b0, 32'h0);

        // Address change and request drop mid-fill do not abort the 0x40 fill.
        cyc(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        expOut("fill40.chg", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        cyc(1'b0, 32'h0000_0080, 1'b1, 32'h0);
        expOut("fill40.drop", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        cyc(1'b1, 32'h0000_0080, 1'b0, 32'h8C22_0004);
        expOut("fill40.end", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        cyc(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        expOut("miss80", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0080, 1'b0, 32'h2222_2222);
        expOut("fill80", 1'b0, 32'h0, 1'b1, 32'h0000_0080);
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        expOut("miss40.evicted", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'h3333_3333);
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        expOut("hit40.refill", 1'b1, 32'h3333_3333, 1'b0, 32'h0);

        // Neighbouring index 1 (0x44) is independent.
        cyc(1'b1, 32'h0000_0044, 1'b1, 32'h0);
        expOut("miss44", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0044, 1'b0, 32'h4444_4444);
        cyc(1'b1, 32'h0000_0044, 1'b1, 32'h0);
        expOut("hit44", 1'b1, 32'h4444_4444, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        expOut("hit40.kept", 1'b1, 32'h3333_3333, 1'b0, 32'h0);

        // Reset mid-fill: iREN drops at once and cached lines are lost.
        cyc(1'b1, 32'h0000_0048, 1'b1, 32'h0);
        cyc(1'b1, 32'h0000_0048, 1'b1, 32'h0);
        expOut("fill48", 1'b0, 32'h0, 1'b1, 32'h0000_0048);
        nRST = 1'b0;
        #1;
        expOut("rst.midfill", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'h5555_5555);
        nRST = 1'b1;
        #1;
        expOut("miss40.afterrst", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'h6666_6666);
        expOut("fill40.afterrst", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0000_0040, 1'b1, 32'h0);
            expOut("hit40.held", 1'b1, 32'h6666_6666, 1'b0, 32'h0);
        end
        cyc(1'b0, 32'h0000_0040, 1'b1, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("stats.miss_count", miss_count, 32'd1);
        chk("stats.hit_count", hit_count, 32'd3);
`endif
        expOut("final.idle", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SETS, default 16: number of direct-mapped one-word frames; power of two, range 2 to 256.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored.
REQ-006 ihit  output  1  requested word is valid on imemload this cycle.
REQ-007 imemload  output  32  instruction word returned to the datapath.
REQ-008 iREN  output  1  memory-side read request.
REQ-009 iaddr  output  32  memory-side word address; bits [1:0] = 0.
REQ-010 iwait  input  1  memory busy; iload is valid in a cycle with iREN=1 and iwait=0.
REQ-011 iload  input  32  memory-side read data.

Function
REQ-012 Address split SHALL be: index = addr[IDX+1:2] with IDX = log2(SETS); tag = addr[31:IDX+2].
REQ-013 Each frame SHALL hold valid (1b), tag and data (32b).
REQ-014 FSM states SHALL be IDLE and FILL.
REQ-015 In IDLE, ihit SHALL be combinationally 1 iff imemREN=1, the indexed frame is valid and its tag matches; imemload SHALL then carry the frame data.
REQ-016 When imemload is not a hit it SHALL be 0.
REQ-017 In IDLE, a miss (imemREN=1, no hit) SHALL latch imemaddr and move to FILL on the next edge.
REQ-018 In FILL: iREN=1 and iaddr={latched[31:2],2'b00}; ihit=0 regardless of inputs.
REQ-019 In FILL, when iwait=0, the cache SHALL write valid=1, tag and iload into the latched frame and return to IDLE on that edge.
REQ-020 Miss latency SHALL be: the fill takes N+1 cycles for N cycles of iwait=1; ihit rises on the first IDLE cycle after the fill.
REQ-021 A fill SHALL NOT be aborted: if imemREN drops or imemaddr changes during FILL, the fill completes, and the new address is evaluated in IDLE.
REQ-022 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-023 A fill into an occupied frame SHALL overwrite it; an icache never writes back.
REQ-024 A hit SHALL NOT change any state except the statistics counters.

Reset
REQ-025 When nRST=0, the FSM SHALL go to IDLE, every valid bit SHALL clear and the latched address SHALL clear; tag and data need not reset.
REQ-026 Reset SHALL take effect immediately, including mid-FILL; iREN drops the same cycle and the pending fill is discarded.
REQ-027 After reset, ihit=0, imemload=0, iREN=0 and iaddr=0.

Configuration
REQ-028 With ICACHE_STATS_EN defined, the block SHALL add outputs hit_count[31:0] and miss_count[31:0], reset to 0 and wrapping at 2^32.
REQ-029 hit_count SHALL increment on every cycle with ihit=1; miss_count SHALL increment once per IDLE-to-FILL transition.
REQ-030 Without ICACHE_STATS_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 cpu_types_pkg SHALL hold word_t (reused) plus new types icache_frame_t (valid, tag, data) and icachef_t (tag/idx/bytoff address view) at the default SETS.
REQ-032 The block SHALL be a single module; no sub-module is warranted.
REQ-033 The frame array SHALL be flip-flops indexed by idx.

Verification
REQ-034 After reset, read 0x00000040 with iwait=1 for 3 cycles -> iREN=1 and iaddr=0x40 for 4 cycles, ihit=0, then ihit=1 with imemload=iload value 0x8C220004.
REQ-035 Repeat read of 0x00000040 -> ihit=1 in the same cycle, iREN stays 0.
REQ-036 Read 0x00000440 (same index, different tag, SETS=16) -> miss and refill; 0x00000040 then misses again.
REQ-037 Change imemaddr to 0x80 mid-fill of 0x40 -> fill of 0x40 completes, then the 0x80 miss starts; no ihit during FILL.
REQ-038 Assert nRST mid-FILL -> iREN=0 immediately; a prior hit address now misses.
REQ-039 With ICACHE_STATS_EN: 1 miss then 3 held-hit cycles -> miss_count=1, hit_count=3.
